// File: rtl/cond_pkg.sv
// Shared constants for the condition unit:
// condition codes, flag bit positions, flag-write selects.
package cond_pkg;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational condition-code test
// of Cond against the architectural flags.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       pass_o
);

  logic n, z, c, v;
  logic ge;

  assign n  = flags_i[FLAG_N];
  assign z  = flags_i[FLAG_Z];
  assign c  = flags_i[FLAG_C];
  assign v  = flags_i[FLAG_V];
  assign ge = (n == v);

  // decode the 4-bit condition field
  always_comb begin
    pass_o = 1'b0;
    unique case (cond_i)
      COND_EQ: pass_o = z;
      COND_NE: pass_o = ~z;
      COND_CS: pass_o = c;
      COND_CC: pass_o = ~c;
      COND_MI: pass_o = n;
      COND_PL: pass_o = ~n;
      COND_VS: pass_o = v;
      COND_VC: pass_o = ~v;
      COND_HI: pass_o = c & ~z;
      COND_LS: pass_o = ~c | z;
      COND_GE: pass_o = ge;
      COND_LT: pass_o = ~ge;
      COND_GT: pass_o = ~z & ge;
      COND_LE: pass_o = z | ~ge;
      COND_AL: pass_o = 1'b1;
      COND_NV: pass_o = 1'b0;
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execute unit: gates writes,
// owns NZCV flags and exec/skip counters.
module cond_unit
  import cond_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InstrValid,
  input  logic [3:0]       Cond,
  input  logic [3:0]       ALUFlags,
  input  logic [1:0]       FlagW,
  input  logic             PCS,
  input  logic             RegW,
  input  logic             MemW,
  input  logic             NoWrite,
  input  logic             CntClr,
  output logic             PCSrc,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             CondEx,
  output logic             CondExDelayed,
  output logic [3:0]       Flags,
  output logic [CNT_W-1:0] ExecCount,
  output logic [CNT_W-1:0] SkipCount
);

  logic [3:0]       flags_q, flags_d;
  logic             cxd_q, cxd_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             pass;
  logic             cond_ex;

  // Evaluated from the registered flags so a
  // flag write is seen only on the next cycle.
  cond_check u_check (
    .cond_i  (Cond),
    .flags_i (flags_q),
    .pass_o  (pass)
  );

  assign cond_ex  = InstrValid & pass;
  assign CondEx   = cond_ex;
  assign PCSrc    = PCS & cond_ex;
  assign RegWrite = RegW & cond_ex & ~NoWrite;
  assign MemWrite = MemW & cond_ex;

  assign Flags         = flags_q;
  assign CondExDelayed = cxd_q;
  assign ExecCount     = exec_q;
  assign SkipCount     = skip_q;

  // flag update: only executed instructions write,
  // and only the selected flag pairs
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && FlagW[FW_NZ]) begin
      flags_d[FLAG_N] = ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
    end
    if (cond_ex && FlagW[FW_CV]) begin
      flags_d[FLAG_C] = ALUFlags[FLAG_C];
      flags_d[FLAG_V] = ALUFlags[FLAG_V];
    end
  end

  // delayed CondEx tracks valid instructions only
  always_comb begin
    cxd_d = cxd_q;
    if (InstrValid) cxd_d = cond_ex;
  end

  // saturating counters; clear beats increment
  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (CntClr) begin
      exec_d = '0;
      skip_d = '0;
    end else if (InstrValid) begin
      if (cond_ex) begin
        if (exec_q != {CNT_W{1'b1}})
          exec_d = exec_q + CNT_W'(1);
      end else begin
        if (skip_q != {CNT_W{1'b1}})
          skip_d = skip_q + CNT_W'(1);
      end
    end
  end

  // state registers, async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 4'b0000;
      cxd_q   <= 1'b0;
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      flags_q <= flags_d;
      cxd_q   <= cxd_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

endmodule

// File: tb/tb_cond_unit.sv
// Directed scoreboard bench for cond_unit
// with 2-bit counters to reach saturation.
module tb_cond_unit;

  logic       clk;
  logic       reset;
  logic       InstrValid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, NoWrite, CntClr;
  logic       PCSrc, RegWrite, MemWrite;
  logic       CondEx, CondExDelayed;
  logic [3:0] Flags;
  logic [1:0] ExecCount, SkipCount;

  cond_unit #(.CNT_W(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .InstrValid    (InstrValid),
    .Cond          (Cond),
    .ALUFlags      (ALUFlags),
    .FlagW         (FlagW),
    .PCS           (PCS),
    .RegW          (RegW),
    .MemW          (MemW),
    .NoWrite       (NoWrite),
    .CntClr        (CntClr),
    .PCSrc         (PCSrc),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .CondEx        (CondEx),
    .CondExDelayed (CondExDelayed),
    .Flags         (Flags),
    .ExecCount     (ExecCount),
    .SkipCount     (SkipCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic       cx, pc, rw, mw;
    logic [3:0] fl;
    logic       cxd;
    logic [1:0] ex, sk;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vid = 0;

  task automatic chk(input string nm, input int id,
                     input logic [3:0] act,
                     input logic [3:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL v%0d %s: got %b want %b",
               id, nm, act, exp);
    end
  endtask

  // monitor: compare outputs mid-cycle against
  // the oldest pending expectation
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      vectors++;
      chk("CondEx", e.id, {3'b0, CondEx}, {3'b0, e.cx});
      chk("PCSrc", e.id, {3'b0, PCSrc}, {3'b0, e.pc});
      chk("RegWrite", e.id, {3'b0, RegWrite}, {3'b0, e.rw});
      chk("MemWrite", e.id, {3'b0, MemWrite}, {3'b0, e.mw});
      chk("Flags", e.id, Flags, e.fl);
      chk("CondExDelayed", e.id,
          {3'b0, CondExDelayed}, {3'b0, e.cxd});
      chk("ExecCount", e.id, {2'b0, ExecCount}, {2'b0, e.ex});
      chk("SkipCount", e.id, {2'b0, SkipCount}, {2'b0, e.sk});
    end
  end

  // drive one cycle of inputs just after the edge
  // and queue the hand-computed response
  task automatic vec(
    input logic rs, input logic iv,
    input logic [3:0] cd, input logic [3:0] af,
    input logic [1:0] fw,
    input logic ps, input logic rg, input logic mm,
    input logic nw, input logic cl,
    input logic ecx, input logic epc,
    input logic erw, input logic emw,
    input logic [3:0] efl, input logic ecxd,
    input logic [1:0] eex, input logic [1:0] esk);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rs; InstrValid = iv; Cond = cd;
    ALUFlags = af; FlagW = fw; PCS = ps;
    RegW = rg; MemW = mm; NoWrite = nw; CntClr = cl;
    e.id = vid; e.cx = ecx; e.pc = epc;
    e.rw = erw; e.mw = emw; e.fl = efl;
    e.cxd = ecxd; e.ex = eex; e.sk = esk;
    sb.push_back(e);
    vid++;
  endtask

  initial begin
    reset = 1'b0; InstrValid = 1'b0; Cond = 4'h0;
    ALUFlags = 4'h0; FlagW = 2'b00; PCS = 1'b0;
    RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
    CntClr = 1'b0;
    //   rs iv cond     alu      fw    ps rg mm nw cl   cx pc rw mw fl       cxd ex sk
    // in reset: AL passes on zero flags, write dropped
    vec(0, 1, 4'b1110, 4'b1111, 2'b11, 1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0000, 0, 0, 0);
    // released: EQ fails on Z=0
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0, 0);
    // AL writes Z
    vec(1, 1, 4'b1110, 4'b0100, 2'b11, 0, 1, 0, 0, 0,  1, 0, 1, 0, 4'b0000, 0, 0, 1);
    // EQ now passes; NoWrite blocks RegWrite
    vec(1, 1, 4'b0000, 4'b0000, 2'b00, 0, 1, 1, 1, 0,  1, 0, 0, 1, 4'b0100, 1, 1, 1);
    // NE fails: flags held, no RegWrite
    vec(1, 1, 4'b0001, 4'b1010, 2'b11, 0, 1, 0, 0, 0,  0, 0, 0, 0, 4'b0100, 1, 2, 1);
    // invalid: everything squashed, state held
    vec(1, 0, 4'b1110, 4'b0000, 2'b11, 1, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0100, 0, 2, 2);
    vec(1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 1, 0, 0,  1, 0, 0, 1, 4'b0100, 0, 2, 2);
    vec(1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100, 1, 3, 2);
    vec(1, 1, 4'b1110, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100, 1, 3, 2);
    // exec saturated at 3; clear flags
    vec(1, 1, 4'b1110, 4'b0000, 2'b11, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0100, 1, 3, 2);
    // NZ-only write of 1111
    vec(1, 1, 4'b1110, 4'b1111, 2'b10, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 1, 3, 2);
    // GE fails (N=1,V=0); CV write dropped
    vec(1, 1, 4'b1010, 4'b1111, 2'b01, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1100, 1, 3, 2);
    // LT passes; CV write
    vec(1, 1, 4'b1011, 4'b0011, 2'b01, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1100, 0, 3, 3);
    // NV never passes; skip saturated
    vec(1, 1, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1111, 1, 3, 3);
    // HI fails (Z=1) with clear
    vec(1, 1, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 1,  0, 0, 0, 0, 4'b1111, 0, 3, 3);
    // LS passes with clear: clear wins
    vec(1, 1, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, 0, 1,  1, 0, 0, 0, 4'b1111, 0, 0, 0);
    // GT fails, LE passes
    vec(1, 1, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b1111, 1, 0, 0);
    vec(1, 1, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b1111, 0, 0, 1);
    // reset mid-cycle: clears with no edge
    vec(0, 1, 4'b1110, 4'b0101, 2'b11, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4'b0000, 0, 0, 0);
    // flag write under reset was dropped
    vec(1, 0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 0, 0, 0);
    // NE passes on zero flags
    vec(1, 1, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 0,  1, 1, 0, 0, 4'b0000, 0, 0, 0);
    vec(1, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0,  0, 0, 0, 0, 4'b0000, 1, 1, 0);
    // bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d pending want 0",
               sb.size());
    end
    if (vectors != vid) begin
      miscompares++;
      $display("FAIL count: got %0d want %0d",
               vectors, vid);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
